// File: rtl/prog_instruction_memory.sv
// Byte-addressed little-endian instruction memory with a pipelined fetch port
// and a runtime load port that rewrites program words while fetch is blocked.
module prog_instruction_memory #(
    parameter int unsigned DEPTH_BYTES = 1024,
    parameter int unsigned ADDR_W      = 32,
    parameter logic [31:0] NOP_WORD    = 32'h0000_0013
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_pc,
    output logic              fetch_ready,
    output logic              instr_valid,
    output logic [31:0]       instruction_code,
    output logic              instr_fault,
    input  logic              instr_stall,
    input  logic              load_mode,
    input  logic              load_we,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [31:0]       load_data,
    input  logic [3:0]        load_be,
    output logic              load_err
);

    localparam int unsigned       IDX_W     = $clog2(DEPTH_BYTES);
    localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(DEPTH_BYTES - 4);

    typedef enum logic [1:0] {StRun, StHold, StLoad} state_e;

    state_e           state_q;
    logic             run_q;
    logic             valid_q;
    logic             fault_q;
    logic             load_err_q;
    logic [31:0]      code_q;

    logic [7:0]       mem [DEPTH_BYTES];

    logic             fetch_bad;
    logic             load_bad;
    logic             accept;
    logic             in_load;
    logic             load_wr;
    logic [IDX_W-1:0] fetch_idx;
    logic [IDX_W-1:0] load_idx;
    logic [31:0]      fetch_word;

    // Range checks compare the raw address against the last word base, so no
    // addition is involved and the top of the address space cannot wrap.
    always_comb begin
        fetch_bad = (fetch_pc[1:0] != 2'b00) || (fetch_pc > LAST_WORD);
        load_bad  = (load_addr[1:0] != 2'b00) || (load_addr > LAST_WORD);
        fetch_idx = {fetch_pc[IDX_W-1:2], 2'b00};
        load_idx  = {load_addr[IDX_W-1:2], 2'b00};
        fetch_word = {mem[fetch_idx + IDX_W'(3)], mem[fetch_idx + IDX_W'(2)],
                      mem[fetch_idx + IDX_W'(1)], mem[fetch_idx]};
    end

    // Ready is withheld while a response is stalled or LOAD is requested so an
    // accepted request can never be overwritten or dropped.
    always_comb begin
        fetch_ready = run_q && !load_mode && !(instr_stall && valid_q);
        accept      = fetch_req && fetch_ready;
        in_load     = (state_q == StLoad);
        load_wr     = in_load && load_we && !load_bad;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StRun;
            run_q      <= 1'b0;
            valid_q    <= 1'b0;
            code_q     <= NOP_WORD;
            fault_q    <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            load_err_q <= in_load && load_we && load_bad;
            unique case (state_q)
                StRun: begin
                    if (accept) begin
                        valid_q <= 1'b1;
                        code_q  <= fetch_bad ? NOP_WORD : fetch_word;
                        fault_q <= fetch_bad;
                        run_q   <= 1'b1;
                    end else if (instr_stall && valid_q) begin
                        state_q <= StHold;
                        run_q   <= 1'b0;
                    end else begin
                        valid_q <= 1'b0;
                        if (load_mode) begin
                            state_q <= StLoad;
                            run_q   <= 1'b0;
                        end else begin
                            run_q <= 1'b1;
                        end
                    end
                end
                StHold: begin
                    // The held response is consumed on the exit edge.
                    if (!instr_stall) begin
                        valid_q <= 1'b0;
                        if (load_mode) begin
                            state_q <= StLoad;
                            run_q   <= 1'b0;
                        end else begin
                            state_q <= StRun;
                            run_q   <= 1'b1;
                        end
                    end
                end
                StLoad: begin
                    valid_q <= 1'b0;
                    if (!load_mode) begin
                        state_q <= StRun;
                        run_q   <= 1'b1;
                    end
                end
                default: begin
                    state_q <= StRun;
                    run_q   <= 1'b0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    // Storage has no reset so a loaded program survives a core reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (load_wr && load_be[i]) begin
                mem[load_idx + IDX_W'(i)] <= load_data[8*i +: 8];
            end
        end
    end

    assign instr_valid      = valid_q;
    assign instruction_code = code_q;
    assign instr_fault      = fault_q;
    assign load_err         = load_err_q;

endmodule

// File: tb/tb_prog_instruction_memory.sv
// Directed self-checking bench for prog_instruction_memory: load, fetch, fault,
// partial write, stall, load errors and mid-stream reset.
module tb_prog_instruction_memory;

    localparam int unsigned DEPTH = 1024;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        fetch_req = 1'b0;
    logic [31:0] fetch_pc = '0;
    logic        fetch_ready;
    logic        instr_valid;
    logic [31:0] instruction_code;
    logic        instr_fault;
    logic        instr_stall = 1'b0;
    logic        load_mode = 1'b0;
    logic        load_we = 1'b0;
    logic [31:0] load_addr = '0;
    logic [31:0] load_data = '0;
    logic [3:0]  load_be = '0;
    logic        load_err;

    int checks = 0;
    int errors = 0;

    prog_instruction_memory #(
        .DEPTH_BYTES(DEPTH),
        .ADDR_W     (32),
        .NOP_WORD   (NOP)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .fetch_req       (fetch_req),
        .fetch_pc        (fetch_pc),
        .fetch_ready     (fetch_ready),
        .instr_valid     (instr_valid),
        .instruction_code(instruction_code),
        .instr_fault     (instr_fault),
        .instr_stall     (instr_stall),
        .load_mode       (load_mode),
        .load_we         (load_we),
        .load_addr       (load_addr),
        .load_data       (load_data),
        .load_be         (load_be),
        .load_err        (load_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic enter_load();
        fetch_req = 1'b0;
        load_mode = 1'b1;
        tick();
    endtask

    task automatic write_word(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        load_we   = 1'b1;
        load_addr = a;
        load_data = d;
        load_be   = be;
        tick();
        load_we   = 1'b0;
    endtask

    task automatic exit_load();
        load_mode = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (instr_valid !== 1'b0) begin errors++;
            $display("FAIL reset_valid got %b want 0", instr_valid); end
        checks++; if (instruction_code !== NOP) begin errors++;
            $display("FAIL reset_code got %h want %h", instruction_code, NOP); end
        checks++; if (instr_fault !== 1'b0) begin errors++;
            $display("FAIL reset_fault got %b want 0", instr_fault); end
        checks++; if (load_err !== 1'b0) begin errors++;
            $display("FAIL reset_load_err got %b want 0", load_err); end
        checks++; if (fetch_ready !== 1'b0) begin errors++;
            $display("FAIL reset_ready_low got %b want 0", fetch_ready); end
        reset = 1'b1;
        tick();
        checks++; if (fetch_ready !== 1'b1) begin errors++;
            $display("FAIL reset_ready_after got %b want 1", fetch_ready); end
    endtask

    task automatic test_load_sequence();
        logic [31:0] pcs [3];
        logic [31:0] exp [3];
        pcs = '{32'd0, 32'd4, 32'd8};
        exp = '{32'h0000_12B7, 32'h00C2_D293, 32'h0037_A023};
        enter_load();
        checks++; if (fetch_ready !== 1'b0 || instr_valid !== 1'b0) begin errors++;
            $display("FAIL load_state got ready=%b valid=%b want 0 0", fetch_ready, instr_valid); end
        for (int i = 0; i < 3; i++) write_word(pcs[i], exp[i], 4'hF);
        write_word(DEPTH - 4, 32'hDEAD_BEEF, 4'hF);
        exit_load();
        checks++; if (fetch_ready !== 1'b1) begin errors++;
            $display("FAIL load_exit_ready got %b want 1", fetch_ready); end
        fetch_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            fetch_pc = pcs[i];
            tick();
            checks++;
            if (instr_valid !== 1'b1 || instruction_code !== exp[i] || instr_fault !== 1'b0) begin
                errors++;
                $display("FAIL seq_fetch%0d got v=%b code=%h f=%b want 1 %h 0",
                         i, instr_valid, instruction_code, instr_fault, exp[i]);
            end
        end
        fetch_req = 1'b0;
        tick();
        checks++; if (instr_valid !== 1'b0) begin errors++;
            $display("FAIL seq_valid_drop got %b want 0", instr_valid); end
    endtask

    task automatic test_fault();
        logic [31:0] pcs [4];
        logic [31:0] exp [4];
        logic        flt [4];
        pcs = '{32'h2, DEPTH - 4, DEPTH, 32'hFFFF_FFFC};
        exp = '{NOP, 32'hDEAD_BEEF, NOP, NOP};
        flt = '{1'b1, 1'b0, 1'b1, 1'b1};
        fetch_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            fetch_pc = pcs[i];
            tick();
            checks++;
            if (instr_valid !== 1'b1 || instruction_code !== exp[i] || instr_fault !== flt[i]) begin
                errors++;
                $display("FAIL fault_pc_%h got v=%b code=%h f=%b want 1 %h %b",
                         pcs[i], instr_valid, instruction_code, instr_fault, exp[i], flt[i]);
            end
        end
        fetch_req = 1'b0;
        tick();
    endtask

    task automatic test_partial_write();
        enter_load();
        write_word(32'd16, 32'h1122_3344, 4'hF);
        write_word(32'd16, 32'hAABB_CCDD, 4'b0101);
        exit_load();
        fetch_req = 1'b1;
        fetch_pc  = 32'd16;
        tick();
        fetch_req = 1'b0;
        checks++; if (instruction_code !== 32'h11BB_33DD || instr_valid !== 1'b1) begin errors++;
            $display("FAIL partial_write got v=%b code=%h want 1 11bb33dd",
                     instr_valid, instruction_code); end
        tick();
    endtask

    task automatic test_stall();
        fetch_req = 1'b1;
        fetch_pc  = 32'd0;
        tick();
        instr_stall = 1'b1;
        fetch_pc    = 32'd4;
        #1;
        checks++; if (fetch_ready !== 1'b0) begin errors++;
            $display("FAIL stall_ready_comb got %b want 0", fetch_ready); end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (instr_valid !== 1'b1 || instruction_code !== 32'h0000_12B7 || fetch_ready !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold%0d got v=%b code=%h rdy=%b want 1 000012b7 0",
                         i, instr_valid, instruction_code, fetch_ready);
            end
        end
        instr_stall = 1'b0;
        tick();
        checks++; if (instr_valid !== 1'b0 || fetch_ready !== 1'b1) begin errors++;
            $display("FAIL stall_release got v=%b rdy=%b want 0 1", instr_valid, fetch_ready); end
        tick();
        fetch_req = 1'b0;
        checks++; if (instr_valid !== 1'b1 || instruction_code !== 32'h00C2_D293) begin errors++;
            $display("FAIL stall_next got v=%b code=%h want 1 00c2d293", instr_valid, instruction_code); end
        tick();
        checks++; if (instr_valid !== 1'b0) begin errors++;
            $display("FAIL stall_no_dup got %b want 0", instr_valid); end
    endtask

    task automatic test_load_err();
        enter_load();
        load_we = 1'b1; load_addr = 32'h6; load_data = 32'hFFFF_FFFF; load_be = 4'hF;
        tick();
        load_we = 1'b0;
        checks++; if (load_err !== 1'b1) begin errors++;
            $display("FAIL load_err_misaligned got %b want 1", load_err); end
        tick();
        checks++; if (load_err !== 1'b0) begin errors++;
            $display("FAIL load_err_pulse got %b want 0", load_err); end
        load_we = 1'b1; load_addr = DEPTH;
        tick();
        load_we = 1'b0;
        checks++; if (load_err !== 1'b1) begin errors++;
            $display("FAIL load_err_range got %b want 1", load_err); end
        exit_load();
        load_we = 1'b1; load_addr = 32'h0;
        tick();
        load_we = 1'b0;
        checks++; if (load_err !== 1'b0) begin errors++;
            $display("FAIL load_we_in_run got %b want 0", load_err); end
        fetch_req = 1'b1;
        fetch_pc  = 32'd4;
        tick();
        checks++; if (instruction_code !== 32'h00C2_D293) begin errors++;
            $display("FAIL load_err_mem4 got %h want 00c2d293", instruction_code); end
        fetch_pc = 32'd0;
        tick();
        fetch_req = 1'b0;
        checks++; if (instruction_code !== 32'h0000_12B7) begin errors++;
            $display("FAIL load_err_mem0 got %h want 000012b7", instruction_code); end
        tick();
    endtask

    task automatic test_load_during_stall();
        fetch_req = 1'b1;
        fetch_pc  = 32'd8;
        tick();
        fetch_req   = 1'b0;
        instr_stall = 1'b1;
        load_mode   = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (instr_valid !== 1'b1 || instruction_code !== 32'h0037_A023) begin errors++;
                $display("FAIL lds_hold%0d got v=%b code=%h want 1 0037a023",
                         i, instr_valid, instruction_code); end
        end
        instr_stall = 1'b0;
        tick();
        checks++; if (instr_valid !== 1'b0 || fetch_ready !== 1'b0) begin errors++;
            $display("FAIL lds_in_load got v=%b rdy=%b want 0 0", instr_valid, fetch_ready); end
        write_word(32'h20, 32'h1234_5678, 4'hF);
        exit_load();
        fetch_req = 1'b1;
        fetch_pc  = 32'h20;
        tick();
        fetch_req = 1'b0;
        checks++; if (instr_valid !== 1'b1 || instruction_code !== 32'h1234_5678) begin errors++;
            $display("FAIL lds_visibility got v=%b code=%h want 1 12345678",
                     instr_valid, instruction_code); end
        tick();
    endtask

    task automatic test_reset_mid();
        fetch_req = 1'b1;
        fetch_pc  = 32'd0;
        tick();
        instr_stall = 1'b1;
        fetch_pc    = 32'd4;
        tick();
        #2;
        reset = 1'b0;
        #1;
        checks++; if (instr_valid !== 1'b0 || fetch_ready !== 1'b0) begin errors++;
            $display("FAIL midreset_async got v=%b rdy=%b want 0 0", instr_valid, fetch_ready); end
        checks++; if (instruction_code !== NOP || instr_fault !== 1'b0) begin errors++;
            $display("FAIL midreset_code got %h f=%b want %h 0", instruction_code, instr_fault, NOP); end
        instr_stall = 1'b0;
        fetch_req   = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        tick();
        fetch_req = 1'b1;
        fetch_pc  = 32'd0;
        tick();
        fetch_req = 1'b0;
        checks++; if (instr_valid !== 1'b1 || instruction_code !== 32'h0000_12B7) begin errors++;
            $display("FAIL midreset_refetch got v=%b code=%h want 1 000012b7",
                     instr_valid, instruction_code); end
        tick();
    endtask

    initial begin
        test_reset();
        test_load_sequence();
        test_fault();
        test_partial_write();
        test_stall();
        test_load_err();
        test_load_during_stall();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got running want finished");
        $fatal(1, "timeout");
    end

endmodule
